// File: rtl/fpu_cvt_pkg.sv
// Shared types and helpers for the integer-to-float conversion path.
package fpu_cvt_pkg;

    localparam int SIG_W = 33;
    localparam int EXP_W = 7;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } rm_e;

    typedef struct packed {
        logic [SIG_W-1:0] sig;
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic             zero;
        rm_e              rm;
    } int2fp_norm_s;

    // Leading zeros of a byte; result is meaningless for an all-zero byte.
    function automatic logic [2:0] lz8(input logic [7:0] b);
        lz8 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) lz8 = 3'(7 - i);
        end
    endfunction

endpackage

// File: rtl/int_to_fp_normalize_lzc64.sv
// Combinational 64-bit leading-zero counter, returns 64 for a zero input.
module lzc64
    import fpu_cvt_pkg::*;
(
    input  logic [63:0] data,
    output logic [6:0]  count
);

    logic [7:0]      byte_nz;
    logic [7:0][2:0] byte_lz;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign byte_nz[gi] = |data[gi*8 +: 8];
            assign byte_lz[gi] = lz8(data[gi*8 +: 8]);
        end
    endgenerate

    // Ascending scan so the most significant non-zero byte wins.
    always_comb begin
        count = 7'd64;
        for (int g = 0; g < 8; g++) begin
            if (byte_nz[g]) count = {1'b0, 3'(7 - g), byte_lz[g]};
        end
    end

endmodule

// File: rtl/int_to_fp_normalize.sv
// Two-stage normalizer: S1 takes magnitude and leading-zero count, S2 shifts and folds sticky.
module int_to_fp_normalize
    import fpu_cvt_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_signed,
    input  logic             in_is64,
    input  logic [2:0]       in_rm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic [2:0]       out_rm
);

    logic         s1_valid_reg;
    logic [63:0]  s1_mag_reg;
    logic [6:0]   s1_lzc_reg;
    logic         s1_sign_reg;
    rm_e          s1_rm_reg;
    logic         s2_valid_reg;
    int2fp_norm_s s2_reg;

    logic         s2_adv;
    logic         accept;
    logic [63:0]  op_ext;
    logic         op_sign;
    logic [63:0]  op_mag;
    logic [6:0]   op_lzc;
    logic [63:0]  norm;
    logic         norm_zero;
    int2fp_norm_s s2_next;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign accept   = in_valid && in_ready;

    // 32-bit operands live in the low word and are extended by signedness.
    assign op_ext  = in_is64 ? in_data[63:0]
                             : {{32{in_signed & in_data[31]}}, in_data[31:0]};
    assign op_sign = in_signed & op_ext[63];
    assign op_mag  = op_sign ? (64'd0 - op_ext) : op_ext;

    lzc64 u_lzc (
        .data  (op_mag),
        .count (op_lzc)
    );

    assign norm      = s1_mag_reg << s1_lzc_reg[5:0];
    assign norm_zero = s1_lzc_reg[6];

    always_comb begin
        s2_next      = '0;
        s2_next.sig  = norm_zero ? '0 : {norm[63:32], |norm[31:0]};
        s2_next.exp  = norm_zero ? '0 : EXP_W'(7'd63 - s1_lzc_reg);
        s2_next.sign = s1_sign_reg & ~norm_zero;
        s2_next.zero = norm_zero;
        s2_next.rm   = s1_rm_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_mag_reg   <= '0;
            s1_lzc_reg   <= '0;
            s1_sign_reg  <= 1'b0;
            s1_rm_reg    <= RNE;
            s2_valid_reg <= 1'b0;
            s2_reg       <= '0;
        end else begin
            if (flush) begin
                s1_valid_reg <= 1'b0;
                s2_valid_reg <= 1'b0;
            end else begin
                if (in_ready) s1_valid_reg <= in_valid;
                if (s2_adv)   s2_valid_reg <= s1_valid_reg;
            end
            if (accept && !flush) begin
                s1_mag_reg  <= op_mag;
                s1_lzc_reg  <= op_lzc;
                s1_sign_reg <= op_sign;
                s1_rm_reg   <= rm_e'(in_rm);
            end
            // Payload only moves with a live entry so stalled outputs never shift.
            if (s2_adv && s1_valid_reg && !flush) s2_reg <= s2_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_sig   = s2_reg.sig;
    assign out_exp   = s2_reg.exp;
    assign out_sign  = s2_reg.sign;
    assign out_zero  = s2_reg.zero;
    assign out_rm    = s2_reg.rm;

endmodule

// File: tb/tb_int_to_fp_normalize.sv
// Bench for int_to_fp_normalize: arithmetic reference model with a per-cycle scoreboard plus directed vectors.
module tb_int_to_fp_normalize;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_signed, in_is64, flush, out_valid, out_ready;
    logic [63:0] in_data;
    logic [2:0]  in_rm, out_rm;
    logic [32:0] out_sig;
    logic [6:0]  out_exp;
    logic        out_sign, out_zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [32:0] sig;
        logic [6:0]  exp;
        logic        sign;
        logic        zero;
        logic [2:0]  rm;
        int          ready;
    } exp_t;

    exp_t q[$];

    int_to_fp_normalize #(.XLEN(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_is64   (in_is64),
        .in_rm     (in_rm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_rm    (out_rm)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: integer value -> magnitude -> MSB position -> 32-bit window plus sticky.
    function automatic exp_t model(input logic [63:0] d, input logic s, input logic is64,
                                   input logic [2:0] rm);
        exp_t        e;
        logic [63:0] val, mag, hi;
        logic        neg;
        int          msb;
        if (is64)            val = d;
        else if (s && d[31]) val = {32'hFFFF_FFFF, d[31:0]};
        else                 val = {32'h0, d[31:0]};
        neg = s && val[63];
        mag = neg ? (64'd0 - val) : val;
        e.rm = rm;
        e.ready = 0;
        if (mag == 64'd0) begin
            e.sig = '0; e.exp = '0; e.sign = 1'b0; e.zero = 1'b1;
        end else begin
            msb = 0;
            for (int i = 63; i >= 0; i--) begin
                if (mag[i]) begin
                    msb = i;
                    break;
                end
            end
            if (msb < 32) begin
                e.sig = 33'(mag) << (32 - msb);
            end else begin
                hi = mag >> (msb - 31);
                e.sig = {hi[31:0], (mag & ((64'd1 << (msb - 31)) - 64'd1)) != 64'd0};
            end
            e.exp = 7'(msb);
            e.sign = neg;
            e.zero = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every cycle the output is valid it must match the oldest outstanding entry.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_valid", out_valid, 1'b0);
                end else begin
                    check("sb_latency", cyc >= q[0].ready, 1'b1);
                    check("sb_sig", out_sig, q[0].sig);
                    check("sb_exp", out_exp, q[0].exp);
                    check("sb_sign", out_sign, q[0].sign);
                    check("sb_zero", out_zero, q[0].zero);
                    check("sb_rm", out_rm, q[0].rm);
                end
            end else if (q.size() != 0 && cyc >= q[0].ready) begin
                check("sb_missing_valid", out_valid, 1'b1);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    e = model(in_data, in_signed, in_is64, in_rm);
                    e.ready = cyc + 2;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", q.size() == 0, 1'b1);
    endtask

    // One isolated input with hand-computed expectations; also pins the 2-cycle latency.
    task automatic run_vec(input string name, input logic [63:0] d, input logic s,
                           input logic is64, input logic [2:0] rm, input logic [32:0] e_sig,
                           input logic [6:0] e_exp, input logic e_sign, input logic e_zero);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        in_is64   = is64;
        in_rm     = rm;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check({name, "_lat1"}, out_valid, 1'b0);
        @(negedge clock);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_sig"}, out_sig, e_sig);
        check({name, "_exp"}, out_exp, e_exp);
        check({name, "_sign"}, out_sign, e_sign);
        check({name, "_zero"}, out_zero, e_zero);
        check({name, "_rm"}, out_rm, rm);
        $display("[TB] vec %s data=%h signed=%0b is64=%0b -> sig=%h exp=%0d sign=%0b zero=%0b",
                 name, d, s, is64, out_sig, out_exp, out_sign, out_zero);
    endtask

    logic [63:0] bp_data [4];

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; in_is64 = 1'b0;
        in_rm = 3'd0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sig", out_sig, 33'd0);
        check("rst_exp", out_exp, 7'd0);
        check("rst_sign", out_sign, 1'b0);
        check("rst_zero", out_zero, 1'b0);
        check("rst_rm", out_rm, 3'd0);
        reset_n = 1'b1;

        run_vec("u32_one",   64'h0000_0000_0000_0001,      1'b0, 1'b0, 3'd0, 33'h1_0000_0000, 7'd0,  1'b0, 1'b0);
        run_vec("s32_m1",    64'hDEAD_BEEF_FFFF_FFFF,      1'b1, 1'b0, 3'd1, 33'h1_0000_0000, 7'd0,  1'b1, 1'b0);
        run_vec("s64_min",   64'h8000_0000_0000_0000,      1'b1, 1'b1, 3'd2, 33'h1_0000_0000, 7'd63, 1'b1, 1'b0);
        run_vec("sticky",    64'h8000_0000_0000_0001,      1'b0, 1'b1, 3'd3, 33'h1_0000_0001, 7'd63, 1'b0, 1'b0);
        run_vec("zero",      64'h0,                        1'b1, 1'b1, 3'd4, 33'h0,           7'd0,  1'b0, 1'b1);
        run_vec("u64_bit32", 64'h0000_0001_2345_6789,      1'b0, 1'b1, 3'd7, 33'h1_2345_6789, 7'd32, 1'b0, 1'b0);
        run_vec("s32_min",   64'h0000_0000_8000_0000,      1'b1, 1'b0, 3'd0, 33'h1_0000_0000, 7'd31, 1'b1, 1'b0);
        run_vec("u32_msb",   64'h0000_0000_8000_0000,      1'b0, 1'b0, 3'd1, 33'h1_0000_0000, 7'd31, 1'b0, 1'b0);
        run_vec("s64_m3",    64'hFFFF_FFFF_FFFF_FFFD,      1'b1, 1'b1, 3'd2, 33'h1_8000_0000, 7'd1,  1'b1, 1'b0);
        drain();

        // Back-to-back stream under random backpressure, scoreboard only.
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom} >> $urandom_range(0, 63);
            in_signed = 1'($urandom_range(0, 1));
            in_is64   = 1'($urandom_range(0, 1));
            in_rm     = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 2) != 0);
        end
        drain();

        // Backpressure: only two of four inputs fit, then release, then flush with out_ready.
        bp_data[0] = 64'h0000_0000_0000_00F0;
        bp_data[1] = 64'h0123_4567_89AB_CDEF;
        bp_data[2] = 64'hFFFF_0000_0000_0000;
        bp_data[3] = 64'h0000_0000_0000_0003;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_signed = 1'b0;
        in_is64   = 1'b1;
        in_rm     = 3'd3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bp_data[i];
            @(negedge clock);
            check("bp_in_ready", in_ready, (i < 2) ? 1'b1 : 1'b0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = bp_data[0];
        @(negedge clock);
        check("flush_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("flush_empty", out_valid, 1'b0);
        run_vec("post_flush", 64'h0000_0000_0000_0500, 1'b0, 1'b1, 3'd4, 33'h1_4000_0000, 7'd10, 1'b0, 1'b0);
        drain();

        // Asynchronous reset with both stages occupied.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0000_0000_0000_0077;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_sig", out_sig, 33'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_vec("post_reset", 64'h0000_0000_FFFF_FF80, 1'b1, 1'b0, 3'd1, 33'h1_0000_0000, 7'd7, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_to_fp_normalize.md
# int_to_fp_normalize

Two-stage pipelined normalizer feeding the integer-to-float32 rounding stage of the FPU conversion path. Takes a 32- or 64-bit integer operand, signed or unsigned, and produces its magnitude normalized to a 33-bit significand with folded sticky bit. It also produces the MSB position, sign, zero flag and a passed-through rounding mode. The downstream rounder consumes these outputs combinationally.

## Interface
- `XLEN`, 64: maximum integer operand width; only 64 is supported.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage-1 can accept.
- `in_data`  in  64  integer operand.
- `in_signed`  in  1  operand is two's complement.
- `in_is64`  in  1  1 = 64-bit operand; 0 = use `in_data[31:0]` only.
- `in_rm`  in  3  rounding mode, passed through.
- `flush`  in  1  kill all in-flight entries.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  rounder accepts.
- `out_sig`  out  33  normalized significand; bit 32 = leading one, bit 0 = OR of all bits below the kept window.
- `out_exp`  out  7  MSB index of the magnitude, 0..63, unsigned in 7 bits.
- `out_sign`  out  1  result negative.
- `out_zero`  out  1  magnitude is zero.
- `out_rm`  out  3  rounding mode.

## Operation
- **Stage 1 (S1) on accept** (`in_valid & in_ready`):
  - For 32-bit operands, the operand is sign-extended if `in_signed`, otherwise zero-extended, to 64 bits.
  - `sign` = `in_signed` & operand bit 63.
  - `mag` = `sign` ? −operand : operand, as 64-bit unsigned. −2^63 yields 0x8000_0000_0000_0000, which is correct.
  - `lzc` = leading-zero count of `mag`, 0..64.
  - S1 registers `mag`, `lzc`, `sign` and `rm`.
- **Stage 2 (S2), on transfer S1→S2:**
  - `norm` = `mag << lzc[5:0]`, 64 bits.
  - `out_sig` = {`norm[63:32]`, |`norm[31:0]`}.
  - `out_exp` = 63 − `lzc`.
  - `out_zero` = (`lzc` == 64).
  - When zero: `out_sig` = 0, `out_exp` = 0, `out_sign` = 0.
- **Handshake:**
  - Each stage holds a valid bit, giving a standard two-entry pipeline.
  - S2 advances when `!s2_valid | out_ready`.
  - S1 advances into S2 when S2 advances.
  - `in_ready` = `!s1_valid` | S1 advances this cycle.
  - Outputs are driven directly from S2 registers and are stable while `out_valid & !out_ready`.
- **Flush:** both valid bits clear on the next edge. An input presented in the flush cycle is dropped. `in_ready` is unaffected.

## Timing
- Latency from accept to `out_valid` is 2 cycles when there is no backpressure.
- Throughput is 1 per cycle.
- Reset values:
  - `s1_valid` = `s2_valid` = 0, so `out_valid` = 0.
  - `out_sig`, `out_exp`, `out_sign`, `out_zero` and `out_rm` are 0.
  - `in_ready` = 1.
- **Backpressure:** with both stages full and `out_ready` = 0, `in_ready` = 0 and nothing changes. When `out_ready` rises, the S2 result retires, S1 moves to S2 and a new input is accepted in the same cycle.
- **Simultaneous flush and `out_ready`:** the S2 entry counts as consumed by the downstream stage, and the pipeline is empty afterwards.
- **Reset mid-operation:** all entries are discarded asynchronously and no partial result is emitted.
- No combinational path from `out_ready` to any output except `in_ready`.

## Structure
- The package `fpu_cvt_pkg` holds:
  - the `rm_e` enum (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7);
  - the `SIG_W`=33 and `EXP_W`=7 constants;
  - the `int2fp_norm_s` payload struct (sig, exp, sign, zero, rm).
- Sub-module `lzc64` is a combinational leading-zero counter: 64-bit input, 7-bit count, with 64 returned for zero input.

## Test plan
- **Unsigned 32-bit 1:** `in_data`=1, `in_is64`=0, `in_signed`=0 → 2 cycles later `out_sig`=0x1_0000_0000, `out_exp`=0, `out_sign`=0, `out_zero`=0.
- **Signed 32-bit −1:** `in_data`=0xFFFF_FFFF, `in_signed`=1, `in_is64`=0 → `out_sign`=1, `out_exp`=0, `out_sig`=0x1_0000_0000.
- **Signed 64-bit minimum:** 0x8000_0000_0000_0000, `in_signed`=1 → `out_sign`=1, `out_exp`=63, `out_sig`=0x1_0000_0000.
- **Sticky fold:** 0x8000_0000_0000_0001 unsigned → `out_exp`=63, `out_sig`=0x1_0000_0001.
- **Zero:** `in_data`=0 → `out_zero`=1, `out_sig`=0, `out_exp`=0.
- **Backpressure then flush:**
  - Stream 4 back-to-back inputs with `out_ready` held 0 → only 2 are accepted (`in_ready` drops on the 3rd) and outputs stay stable.
  - Then assert `flush` → `out_valid`=0 next cycle, and the next accepted input emerges 2 cycles later with correct values.
